// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, qualifies lock, releases domain resets in stages,
// retries on timeout/loss and services host re-lock requests. Runs entirely on refclk.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT  = 74250,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned STAGGER       = 16,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       relock_ack,
  output logic       pll_rst,
  output logic [3:0] domain_rst,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned REL_CYCLES = 3 * STAGGER;
  localparam int unsigned MAX_A      = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned MAX_B      = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
  localparam int unsigned CNT_MAX    = (MAX_B > REL_CYCLES) ? MAX_B : REL_CYCLES;
  localparam int unsigned CW         = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_RST_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sync_q;
  logic          lk;
  logic          armed_q, armed_d;
  logic          ack_q, ack_d;
  logic          pll_rst_q, pll_rst_d;
  logic [3:0]    dom_q, dom_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic [1:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          relock_accept;
  logic          attempt_failed;

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], pll_locked};
  end

  assign lk            = sync_q[1];
  assign relock_accept = relock_req & armed_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CW'(1);
    dom_d          = dom_q;
    retry_d        = retry_q;
    loss_d         = loss_q;
    fail_d         = fail_q;
    ack_d          = 1'b0;
    armed_d        = relock_req ? armed_q : 1'b1;
    attempt_failed = 1'b0;

    if (relock_accept) begin
      ack_d   = 1'b1;
      armed_d = 1'b0;
      dom_d   = 4'b1111;
      retry_d = 2'd0;
      fail_d  = 1'b0;
      state_d = S_RST_PLL;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_RST_PLL: begin
          dom_d = 4'b1111;
          if (cnt_q == CW'(RST_CYCLES - 1)) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            attempt_failed = 1'b1;
          end
        end
        S_STABLE: begin
          // A single dropout restarts qualification without costing a retry
          if (!lk) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
            dom_d   = 4'b1110;
          end
        end
        S_RELEASE: begin
          if (!lk) begin
            attempt_failed = 1'b1;
          end else begin
            if (cnt_q == CW'(STAGGER - 1))     dom_d[1] = 1'b0;
            if (cnt_q == CW'(2 * STAGGER - 1)) dom_d[2] = 1'b0;
            if (cnt_q == CW'(REL_CYCLES - 1)) begin
              dom_d[3] = 1'b0;
              state_d  = S_RUN;
              cnt_d    = '0;
            end
          end
        end
        S_RUN: begin
          cnt_d = cnt_q;
          dom_d = 4'b0000;
          if (!lk) begin
            dom_d   = 4'b1111;
            loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
            retry_d = 2'd0;
            state_d = S_RST_PLL;
            cnt_d   = '0;
          end
        end
        S_FAIL: begin
          cnt_d  = cnt_q;
          dom_d  = 4'b1111;
          fail_d = 1'b1;
        end
        default: begin
          state_d = S_RST_PLL;
          cnt_d   = '0;
          dom_d   = 4'b1111;
        end
      endcase

      // Timeout or lock loss before RUN consumes one attempt
      if (attempt_failed) begin
        dom_d = 4'b1111;
        cnt_d = '0;
        if (retry_q == 2'(MAX_RETRIES - 1)) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end else begin
          retry_d = retry_q + 2'd1;
          state_d = S_RST_PLL;
        end
      end
    end

    pll_rst_d = (state_d == S_RST_PLL) || (state_d == S_FAIL);
    ready_d   = (state_q == S_RUN) && (state_d == S_RUN);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RST_PLL;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      ack_q     <= 1'b0;
      pll_rst_q <= 1'b1;
      dom_q     <= 4'b1111;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      retry_q   <= 2'd0;
      loss_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      ack_q     <= ack_d;
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
    end
  end

  assign relock_ack = ack_q;
  assign pll_rst    = pll_rst_q;
  assign domain_rst = dom_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;
  assign loss_cnt   = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: randomized scenarios checked against a timing model derived
// from the sequencing rules (reset pulse, sync latency, stable window, staggered release).
module tb_pll_lock_sequencer;

  localparam int RST = 4;
  localparam int LT  = 20;
  localparam int STB = 8;
  localparam int STG = 2;
  localparam int MR  = 3;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       relock_ack;
  logic       pll_rst;
  logic [3:0] domain_rst;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  pll_lock_sequencer #(
    .RST_CYCLES   (RST),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(STB),
    .STAGGER      (STG),
    .MAX_RETRIES  (MR)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .relock_ack(relock_ack),
    .pll_rst   (pll_rst),
    .domain_rst(domain_rst),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    @(posedge refclk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Expected outputs at edge e for a sequence entered at edge E, lock sampled high from edge L on.
  function automatic void model(input int e, input int E, input int L,
                                output logic [3:0] dom, output logic rdy, output logic prst);
    int s;
    int r;
    s    = (E + RST + 1 > L + 2) ? E + RST + 1 : L + 2;
    r    = s + STB;
    prst = (e < E + RST);
    for (int i = 0; i < 4; i++) dom[i] = (e < r + i * STG);
    rdy  = (e >= r + 3 * STG + 1);
  endfunction

  task automatic test_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (3) @(posedge refclk);
    #1;
    checks++; if (pll_rst !== 1'b1)       begin errors++; $display("FAIL reset pll_rst: got %b want 1", pll_rst); end
    checks++; if (domain_rst !== 4'b1111) begin errors++; $display("FAIL reset domain_rst: got %b want 1111", domain_rst); end
    checks++; if (ready !== 1'b0)         begin errors++; $display("FAIL reset ready: got %b want 0", ready); end
    checks++; if (fail !== 1'b0)          begin errors++; $display("FAIL reset fail: got %b want 0", fail); end
    checks++; if (relock_ack !== 1'b0)    begin errors++; $display("FAIL reset relock_ack: got %b want 0", relock_ack); end
    checks++; if (retry_cnt !== 2'd0)     begin errors++; $display("FAIL reset retry_cnt: got %0d want 0", retry_cnt); end
    checks++; if (loss_cnt !== 8'd0)      begin errors++; $display("FAIL reset loss_cnt: got %0d want 0", loss_cnt); end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_bringup(input int L);
    logic [3:0] ed;
    logic       er, ep;
    do_reset();
    while (cyc < L + 20) begin
      if (cyc == L - 1) pll_locked = 1'b1;
      tick();
      model(cyc, 0, L, ed, er, ep);
      checks++; if (domain_rst !== ed) begin errors++; $display("FAIL bringup(L=%0d) domain_rst @%0d: got %b want %b", L, cyc, domain_rst, ed); end
      checks++; if (ready !== er)      begin errors++; $display("FAIL bringup(L=%0d) ready @%0d: got %b want %b", L, cyc, ready, er); end
      checks++; if (pll_rst !== ep)    begin errors++; $display("FAIL bringup(L=%0d) pll_rst @%0d: got %b want %b", L, cyc, pll_rst, ep); end
    end
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL bringup retry_cnt: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_glitch(input int g);
    logic [3:0] ed;
    logic       er, ep;
    int         L;
    int         lp;
    L  = int'($urandom_range(10, 5));
    lp = L + g + 1;
    do_reset();
    while (cyc < lp + 20) begin
      if (cyc == L - 1) pll_locked = 1'b1;
      if (cyc == L + g - 1) pll_locked = 1'b0;
      if (cyc == L + g) pll_locked = 1'b1;
      tick();
      model(cyc, 0, lp, ed, er, ep);
      checks++; if (domain_rst !== ed)  begin errors++; $display("FAIL glitch(g=%0d) domain_rst @%0d: got %b want %b", g, cyc, domain_rst, ed); end
      checks++; if (ready !== er)       begin errors++; $display("FAIL glitch(g=%0d) ready @%0d: got %b want %b", g, cyc, ready, er); end
      checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL glitch(g=%0d) retry_cnt @%0d: got %0d want 0", g, cyc, retry_cnt); end
    end
  endtask

  task automatic test_timeout_fail();
    int   p;
    int   q;
    logic ep, ef;
    int   er;
    p = RST + LT;
    do_reset();
    while (cyc < MR * p + 8) begin
      tick();
      if (cyc < MR * p) begin
        ep = (cyc % p < RST);
        er = cyc / p;
        ef = 1'b0;
      end else begin
        ep = 1'b1;
        er = MR - 1;
        ef = 1'b1;
      end
      checks++; if (pll_rst !== ep)       begin errors++; $display("FAIL timeout pll_rst @%0d: got %b want %b", cyc, pll_rst, ep); end
      checks++; if (retry_cnt !== 2'(er)) begin errors++; $display("FAIL timeout retry_cnt @%0d: got %0d want %0d", cyc, retry_cnt, er); end
      checks++; if (fail !== ef)          begin errors++; $display("FAIL timeout fail @%0d: got %b want %b", cyc, fail, ef); end
      checks++; if (ready !== 1'b0)       begin errors++; $display("FAIL timeout ready @%0d: got %b want 0", cyc, ready); end
    end
    // Host relock out of FAIL
    q = cyc + 1 + int'($urandom_range(3, 0));
    while (cyc < q + RST + 2) begin
      if (cyc == q - 1) relock_req = 1'b1;
      if (cyc == q + 2) relock_req = 1'b0;
      tick();
      if (cyc == q) begin
        checks++; if (relock_ack !== 1'b1) begin errors++; $display("FAIL fail-relock ack: got %b want 1", relock_ack); end
        checks++; if (fail !== 1'b0)       begin errors++; $display("FAIL fail-relock fail: got %b want 0", fail); end
        checks++; if (retry_cnt !== 2'd0)  begin errors++; $display("FAIL fail-relock retry_cnt: got %0d want 0", retry_cnt); end
        checks++; if (pll_rst !== 1'b1)    begin errors++; $display("FAIL fail-relock pll_rst: got %b want 1", pll_rst); end
      end
      if (cyc == q + 1) begin
        checks++; if (relock_ack !== 1'b0) begin errors++; $display("FAIL fail-relock ack width: got %b want 0", relock_ack); end
      end
      if (cyc == q + RST) begin
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL fail-relock pll_rst release: got %b want 0", pll_rst); end
      end
    end
  endtask

  task automatic test_run_loss();
    logic [3:0] ed;
    logic       er, ep;
    int         d;
    int         e0;
    int         exp_loss;
    do_reset();
    pll_locked = 1'b1;
    while (cyc < 25) tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss pre-ready: got %b want 1", ready); end
    d = cyc + 1 + int'($urandom_range(5, 0));
    while (cyc < d + 2) begin
      if (cyc == d - 1) pll_locked = 1'b0;
      tick();
      if (cyc == d + 1) begin
        checks++; if (ready !== 1'b1)   begin errors++; $display("FAIL loss sync latency ready: got %b want 1", ready); end
        checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL loss early loss_cnt: got %0d want 0", loss_cnt); end
      end
    end
    checks++; if (ready !== 1'b0)         begin errors++; $display("FAIL loss ready: got %b want 0", ready); end
    checks++; if (domain_rst !== 4'b1111) begin errors++; $display("FAIL loss domain_rst: got %b want 1111", domain_rst); end
    checks++; if (loss_cnt !== 8'd1)      begin errors++; $display("FAIL loss loss_cnt: got %0d want 1", loss_cnt); end
    checks++; if (pll_rst !== 1'b1)       begin errors++; $display("FAIL loss pll_rst: got %b want 1", pll_rst); end
    checks++; if (retry_cnt !== 2'd0)     begin errors++; $display("FAIL loss retry_cnt: got %0d want 0", retry_cnt); end
    pll_locked = 1'b1;
    e0 = cyc;
    while (cyc < e0 + 25) begin
      tick();
      model(cyc, e0, e0 + 1, ed, er, ep);
      checks++; if (domain_rst !== ed) begin errors++; $display("FAIL reseq domain_rst @%0d: got %b want %b", cyc, domain_rst, ed); end
      checks++; if (ready !== er)      begin errors++; $display("FAIL reseq ready @%0d: got %b want %b", cyc, ready, er); end
      checks++; if (pll_rst !== ep)    begin errors++; $display("FAIL reseq pll_rst @%0d: got %b want %b", cyc, pll_rst, ep); end
    end
    // Drive loss_cnt into saturation
    for (int i = 2; i <= 256; i++) begin
      for (int k = 0; k < 60 && ready !== 1'b1; k++) tick();
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL saturation ready timeout at loss %0d: got %b want 1", i, ready);
        break;
      end
      pll_locked = 1'b0;
      repeat (3) tick();
      exp_loss = (i > 255) ? 255 : i;
      checks++; if (loss_cnt !== 8'(exp_loss)) begin errors++; $display("FAIL saturation loss_cnt: got %0d want %0d", loss_cnt, exp_loss); end
      pll_locked = 1'b1;
    end
  endtask

  task automatic test_relock_run();
    logic [3:0] ed;
    logic       er, ep;
    int         q;
    int         d;
    int         acks;
    do_reset();
    pll_locked = 1'b1;
    while (cyc < 25) tick();
    q    = cyc + 1 + int'($urandom_range(3, 0));
    acks = 0;
    while (cyc < q + 25) begin
      if (cyc == q - 1) relock_req = 1'b1;
      if (cyc == q + 9) relock_req = 1'b0;
      tick();
      if (relock_ack === 1'b1) acks++;
      if (cyc >= q) begin
        model(cyc, q, q - 100, ed, er, ep);
        checks++; if (domain_rst !== ed) begin errors++; $display("FAIL relock domain_rst @%0d: got %b want %b", cyc, domain_rst, ed); end
        checks++; if (ready !== er)      begin errors++; $display("FAIL relock ready @%0d: got %b want %b", cyc, ready, er); end
        checks++; if (pll_rst !== ep)    begin errors++; $display("FAIL relock pll_rst @%0d: got %b want %b", cyc, pll_rst, ep); end
      end
      if (cyc == q) begin
        checks++; if (relock_ack !== 1'b1) begin errors++; $display("FAIL relock ack: got %b want 1", relock_ack); end
      end
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL relock ack count: got %0d want 1", acks); end
    // Lock loss and relock decided on the same edge
    d = cyc + 1;
    while (cyc < d + 2) begin
      if (cyc == d - 1) pll_locked = 1'b0;
      if (cyc == d + 1) relock_req = 1'b1;
      tick();
    end
    relock_req = 1'b0;
    checks++; if (relock_ack !== 1'b1)    begin errors++; $display("FAIL simul ack: got %b want 1", relock_ack); end
    checks++; if (loss_cnt !== 8'd0)      begin errors++; $display("FAIL simul loss_cnt: got %0d want 0", loss_cnt); end
    checks++; if (ready !== 1'b0)         begin errors++; $display("FAIL simul ready: got %b want 0", ready); end
    checks++; if (domain_rst !== 4'b1111) begin errors++; $display("FAIL simul domain_rst: got %b want 1111", domain_rst); end
  endtask

  task automatic test_async_reset();
    logic [3:0] ed;
    logic       er, ep;
    do_reset();
    pll_locked = 1'b1;
    while (cyc < 16) tick();
    model(cyc, 0, 1, ed, er, ep);
    checks++; if (domain_rst !== ed) begin errors++; $display("FAIL async mid-release domain_rst: got %b want %b", domain_rst, ed); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pll_rst !== 1'b1)       begin errors++; $display("FAIL async pll_rst: got %b want 1", pll_rst); end
    checks++; if (domain_rst !== 4'b1111) begin errors++; $display("FAIL async domain_rst: got %b want 1111", domain_rst); end
    checks++; if (ready !== 1'b0)         begin errors++; $display("FAIL async ready: got %b want 0", ready); end
    rst = 1'b0;
    cyc = 0;
    while (cyc < 25) begin
      tick();
      model(cyc, 0, 1, ed, er, ep);
      checks++; if (domain_rst !== ed) begin errors++; $display("FAIL async restart domain_rst @%0d: got %b want %b", cyc, domain_rst, ed); end
      checks++; if (ready !== er)      begin errors++; $display("FAIL async restart ready @%0d: got %b want %b", cyc, ready, er); end
      checks++; if (pll_rst !== ep)    begin errors++; $display("FAIL async restart pll_rst @%0d: got %b want %b", cyc, pll_rst, ep); end
    end
  endtask

  initial begin
    test_reset();
    test_bringup(10);
    test_bringup(1 + int'($urandom_range(14, 0)));
    test_glitch(5);
    test_glitch(int'($urandom_range(7, 1)));
    test_timeout_fail();
    test_run_loss();
    test_relock_run();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
